id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ID inputs: ID__Valid 1, ID__Rs1 5, ID__Rs2 5, ID__Need_Rs1 1, ID__Need_Rs2 1, ID__Rdst 5, ID__R_WE 1, ID__Read_MEM 1, ID__Write_MEM 1, ID__RDst_S 2, ID__ALU_Op 4, ID__OP1 32, ID__OP2 32, ID__Imm 32, ID__PC 32.
REQ-003 SHALL have control inputs: Need_Stall  in  1  load-use stall from forwarding unit; Flush  in  1  branch/jump kill from EX; Ext_Stall  in  1  memory wait, freezes pipe; Cnt_Clr  in  1  clears stall counter.
REQ-004 SHALL have registered outputs IDex__<field> for every ID__<field> in REQ-002, same widths.
REQ-005 SHALL have outputs: IFid_Hold  out  1  hold PC and IF/ID; EXmem_Bubble  out  1  load bubble into EX/MEM; Stall_Cnt  out  16  stall-cycle count.

Function
REQ-006 SHALL define eff_stall = Need_Stall AND IDex__Valid; Need_Stall with IDex__Valid=0 SHALL be ignored.
REQ-007 SHALL hold one internal flag flush_pend (1 bit).
REQ-008 SHALL apply per rising edge, priority order: (a) rst_n=0; (b) Ext_Stall=1; (c) Flush=1 or flush_pend=1; (d) eff_stall=1; (e) load.
REQ-009 Case (b): all IDex__ registers hold; flush_pend set if Flush=1, else unchanged.
REQ-010 Case (c): load bubble; flush_pend cleared.
REQ-011 Bubble: IDex__Valid, R_WE, Read_MEM, Write_MEM, Need_Rs1, Need_Rs2 = 0; all other IDex__ fields = 0.
REQ-012 Case (d): all IDex__ registers hold.
REQ-013 Case (e): every IDex__ field loads its ID__ input; control fields (R_WE, Read_MEM, Write_MEM, Need_Rs1, Need_Rs2) gated to 0 when ID__Valid=0.
REQ-014 IFid_Hold SHALL be combinational = Ext_Stall OR (eff_stall AND NOT Flush AND NOT flush_pend).
REQ-015 EXmem_Bubble SHALL be combinational = eff_stall AND NOT Ext_Stall AND NOT Flush AND NOT flush_pend.
REQ-016 Latency: ID__ to IDex__ exactly one cycle when case (e).
REQ-017 Stall_Cnt SHALL increment by 1 on each edge where case (b) or case (d) applies; saturate at 16'hFFFF (no wrap).
REQ-018 Cnt_Clr=1 SHALL set Stall_Cnt to 0 on that edge, overriding increment.
REQ-019 Flush and Need_Stall in same cycle: flush wins, bubble loaded, no hold.
REQ-020 Flush during Ext_Stall SHALL never be lost: applied on first edge with Ext_Stall=0.

Reset
REQ-021 On rst_n=0 at rising edge: all IDex__ outputs 0, flush_pend 0, Stall_Cnt 0.
REQ-022 Reset mid-stall or mid-pending-flush SHALL discard both; first post-reset edge is case (e) unless controls dictate otherwise.
REQ-023 IFid_Hold and EXmem_Bubble SHALL be 0 while IDex__Valid=0 and Ext_Stall=0.

Structure
REQ-024 Shared package SHALL hold field widths (REG_ADDR_W=5, DATA_W=32, ALU_OP_W=4), RDst_S encodings (MemtoReg=2'b00) and STALL_CNT_W=16.
REQ-025 One sub-module SHALL be used: stall_counter (saturating 16-bit counter, inc/clr inputs).
REQ-026 Field registers SHALL be a single flat register bank with one next-state mux per REQ-008.

Verification
REQ-027 Load: ID__Valid=1, Rs1=3, OP1=32'h1234, no controls -> next edge IDex__Rs1=3, IDex__OP1=32'h1234, IDex__Valid=1.
REQ-028 Load-use: IDex__Valid=1, Need_Stall=1 for 1 cycle -> IFid_Hold=1, EXmem_Bubble=1, IDex__ unchanged, Stall_Cnt 0->1.
REQ-029 Flush+Need_Stall same cycle -> IFid_Hold=0, next edge IDex__Valid=0, IDex__R_WE=0, Stall_Cnt unchanged.
REQ-030 Ext_Stall=1 for 3 cycles with Flush pulse in cycle 2 -> IDex__ held 3 edges, Stall_Cnt +3, bubble on first edge after Ext_Stall=0.
REQ-031 Stall_Cnt preset to 16'hFFFE, 3 stall cycles -> Stall_Cnt=16'hFFFF, no wrap; Cnt_Clr with stall -> 0.
REQ-032 rst_n=0 during pending flush and stall -> all outputs 0, Stall_Cnt 0; after release, ID__Valid=1 loads next edge.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// Shared widths, encodings and the ID/EX field record used by the ID/EX
// pipeline register and its stall counter.
package id_ex_reg_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 32;
    localparam int ALU_OP_W    = 4;
    localparam int RDST_S_W    = 2;
    localparam int STALL_CNT_W = 16;

    // Writeback source select carried in RDst_S
    localparam logic [RDST_S_W-1:0] RDST_S_MEMTOREG = 2'b00;
    localparam logic [RDST_S_W-1:0] RDST_S_ALU      = 2'b01;
    localparam logic [RDST_S_W-1:0] RDST_S_PC4      = 2'b10;
    localparam logic [RDST_S_W-1:0] RDST_S_IMM      = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  need_rs1;
        logic                  need_rs2;
        logic [REG_ADDR_W-1:0] rdst;
        logic                  r_we;
        logic                  read_mem;
        logic                  write_mem;
        logic [RDST_S_W-1:0]   rdst_s;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [DATA_W-1:0]     op1;
        logic [DATA_W-1:0]     op2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc;
    } id_ex_t;

    // Which of the per-edge update cases applies, in priority order
    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXT_HOLD,
        SEL_BUBBLE,
        SEL_STALL_HOLD,
        SEL_LOAD
    } id_ex_sel_t;

    // An invalid instruction must not carry side-effecting controls into EX
    function automatic id_ex_t gate_ctrl(input id_ex_t f);
        id_ex_t g;
        g = f;
        if (!f.valid) begin
            g.r_we      = 1'b0;
            g.read_mem  = 1'b0;
            g.write_mem = 1'b0;
            g.need_rs1  = 1'b0;
            g.need_rs2  = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/id_ex_reg_stall_counter.sv
// Saturating stall-cycle counter; clear wins over increment.
import id_ex_reg_pkg::*;

module stall_counter #(
    parameter int W = STALL_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with external freeze, load-use stall, flush
// (remembered across a freeze) and a saturating stall-cycle counter.
import id_ex_reg_pkg::*;

module id_ex_reg (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ID__Valid,
    input  logic [REG_ADDR_W-1:0]  ID__Rs1,
    input  logic [REG_ADDR_W-1:0]  ID__Rs2,
    input  logic                   ID__Need_Rs1,
    input  logic                   ID__Need_Rs2,
    input  logic [REG_ADDR_W-1:0]  ID__Rdst,
    input  logic                   ID__R_WE,
    input  logic                   ID__Read_MEM,
    input  logic                   ID__Write_MEM,
    input  logic [RDST_S_W-1:0]    ID__RDst_S,
    input  logic [ALU_OP_W-1:0]    ID__ALU_Op,
    input  logic [DATA_W-1:0]      ID__OP1,
    input  logic [DATA_W-1:0]      ID__OP2,
    input  logic [DATA_W-1:0]      ID__Imm,
    input  logic [DATA_W-1:0]      ID__PC,
    input  logic                   Need_Stall,
    input  logic                   Flush,
    input  logic                   Ext_Stall,
    input  logic                   Cnt_Clr,
    output logic                   IDex__Valid,
    output logic [REG_ADDR_W-1:0]  IDex__Rs1,
    output logic [REG_ADDR_W-1:0]  IDex__Rs2,
    output logic                   IDex__Need_Rs1,
    output logic                   IDex__Need_Rs2,
    output logic [REG_ADDR_W-1:0]  IDex__Rdst,
    output logic                   IDex__R_WE,
    output logic                   IDex__Read_MEM,
    output logic                   IDex__Write_MEM,
    output logic [RDST_S_W-1:0]    IDex__RDst_S,
    output logic [ALU_OP_W-1:0]    IDex__ALU_Op,
    output logic [DATA_W-1:0]      IDex__OP1,
    output logic [DATA_W-1:0]      IDex__OP2,
    output logic [DATA_W-1:0]      IDex__Imm,
    output logic [DATA_W-1:0]      IDex__PC,
    output logic                   IFid_Hold,
    output logic                   EXmem_Bubble,
    output logic [STALL_CNT_W-1:0] Stall_Cnt
);

    id_ex_t     id_in;
    id_ex_t     ex_q;
    id_ex_t     ex_d;
    id_ex_sel_t sel;
    logic       flush_pend;
    logic       flush_pend_d;
    logic       eff_stall;
    logic       kill;

    assign id_in = '{
        valid:     ID__Valid,
        rs1:       ID__Rs1,
        rs2:       ID__Rs2,
        need_rs1:  ID__Need_Rs1,
        need_rs2:  ID__Need_Rs2,
        rdst:      ID__Rdst,
        r_we:      ID__R_WE,
        read_mem:  ID__Read_MEM,
        write_mem: ID__Write_MEM,
        rdst_s:    ID__RDst_S,
        alu_op:    ID__ALU_Op,
        op1:       ID__OP1,
        op2:       ID__OP2,
        imm:       ID__Imm,
        pc:        ID__PC
    };

    // A stall request against an empty EX slot has nothing to protect
    assign eff_stall = Need_Stall & ex_q.valid;
    assign kill      = Flush | flush_pend;

    assign IFid_Hold    = Ext_Stall | (eff_stall & ~kill);
    assign EXmem_Bubble = eff_stall & ~Ext_Stall & ~kill;

    always_comb begin
        sel          = SEL_LOAD;
        ex_d         = gate_ctrl(id_in);
        flush_pend_d = flush_pend;
        if (!rst_n) begin
            sel          = SEL_RESET;
            ex_d         = '0;
            flush_pend_d = 1'b0;
        end else if (Ext_Stall) begin
            sel          = SEL_EXT_HOLD;
            ex_d         = ex_q;
            flush_pend_d = flush_pend | Flush;
        end else if (kill) begin
            sel          = SEL_BUBBLE;
            ex_d         = '0;
            flush_pend_d = 1'b0;
        end else if (eff_stall) begin
            sel          = SEL_STALL_HOLD;
            ex_d         = ex_q;
        end
    end

    always_ff @(posedge clk) begin
        ex_q       <= ex_d;
        flush_pend <= flush_pend_d;
    end

    stall_counter #(.W(STALL_CNT_W)) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((sel == SEL_EXT_HOLD) || (sel == SEL_STALL_HOLD)),
        .clr   (Cnt_Clr),
        .cnt   (Stall_Cnt)
    );

    assign IDex__Valid     = ex_q.valid;
    assign IDex__Rs1       = ex_q.rs1;
    assign IDex__Rs2       = ex_q.rs2;
    assign IDex__Need_Rs1  = ex_q.need_rs1;
    assign IDex__Need_Rs2  = ex_q.need_rs2;
    assign IDex__Rdst      = ex_q.rdst;
    assign IDex__R_WE      = ex_q.r_we;
    assign IDex__Read_MEM  = ex_q.read_mem;
    assign IDex__Write_MEM = ex_q.write_mem;
    assign IDex__RDst_S    = ex_q.rdst_s;
    assign IDex__ALU_Op    = ex_q.alu_op;
    assign IDex__OP1       = ex_q.op1;
    assign IDex__OP2       = ex_q.op2;
    assign IDex__Imm       = ex_q.imm;
    assign IDex__PC        = ex_q.pc;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed vector bench for id_ex_reg: sequential table of controls and
// hand-computed results, then a counter saturation/clear sequence.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_need_rs1, id_need_rs2, id_r_we, id_read_mem, id_write_mem;
    logic [4:0]  id_rs1, id_rs2, id_rdst;
    logic [1:0]  id_rdst_s;
    logic [3:0]  id_alu_op;
    logic [31:0] id_op1, id_op2, id_imm, id_pc;
    logic        need_stall, flush, ext_stall, cnt_clr;
    logic        ex_valid, ex_need_rs1, ex_need_rs2, ex_r_we, ex_read_mem, ex_write_mem;
    logic [4:0]  ex_rs1, ex_rs2, ex_rdst;
    logic [1:0]  ex_rdst_s;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic        ifid_hold, exmem_bubble;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n),
        .ID__Valid(id_valid), .ID__Rs1(id_rs1), .ID__Rs2(id_rs2),
        .ID__Need_Rs1(id_need_rs1), .ID__Need_Rs2(id_need_rs2), .ID__Rdst(id_rdst),
        .ID__R_WE(id_r_we), .ID__Read_MEM(id_read_mem), .ID__Write_MEM(id_write_mem),
        .ID__RDst_S(id_rdst_s), .ID__ALU_Op(id_alu_op), .ID__OP1(id_op1),
        .ID__OP2(id_op2), .ID__Imm(id_imm), .ID__PC(id_pc),
        .Need_Stall(need_stall), .Flush(flush), .Ext_Stall(ext_stall), .Cnt_Clr(cnt_clr),
        .IDex__Valid(ex_valid), .IDex__Rs1(ex_rs1), .IDex__Rs2(ex_rs2),
        .IDex__Need_Rs1(ex_need_rs1), .IDex__Need_Rs2(ex_need_rs2), .IDex__Rdst(ex_rdst),
        .IDex__R_WE(ex_r_we), .IDex__Read_MEM(ex_read_mem), .IDex__Write_MEM(ex_write_mem),
        .IDex__RDst_S(ex_rdst_s), .IDex__ALU_Op(ex_alu_op), .IDex__OP1(ex_op1),
        .IDex__OP2(ex_op2), .IDex__Imm(ex_imm), .IDex__PC(ex_pc),
        .IFid_Hold(ifid_hold), .EXmem_Bubble(exmem_bubble), .Stall_Cnt(stall_cnt)
    );

    typedef struct {
        logic        rst_n, ns, fl, ex, clr;
        logic        v;
        logic [4:0]  rs1, rdst;
        logic        rwe;
        logic [31:0] op1, pc;
        logic        e_hold, e_bub;
        logic        e_v;
        logic [4:0]  e_rs1, e_rdst;
        logic        e_rwe;
        logic [31:0] e_op1, e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    // Secondary fields derive from the primary ones; all map zero to zero so
    // bubbles and gated controls stay predictable from the primary expectation.
    function automatic logic [4:0]  f_rs2(input logic [4:0] r);   return {r[0], r[4:1]}; endfunction
    function automatic logic [31:0] f_op2(input logic [31:0] d);  return {d[15:0], d[31:16]}; endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] d);  return {d[27:0], d[31:28]}; endfunction

    task automatic drive(input vec_t t);
        rst_n        = t.rst_n;
        need_stall   = t.ns;
        flush        = t.fl;
        ext_stall    = t.ex;
        cnt_clr      = t.clr;
        id_valid     = t.v;
        id_rs1       = t.rs1;
        id_rs2       = f_rs2(t.rs1);
        id_rdst      = t.rdst;
        id_r_we      = t.rwe;
        id_need_rs1  = t.rwe;
        id_need_rs2  = t.rwe & ~t.rs1[1];
        id_read_mem  = t.rwe & t.rs1[0];
        id_write_mem = t.rwe & t.rdst[0];
        id_rdst_s    = t.rdst[1:0];
        id_alu_op    = t.rdst[3:0];
        id_op1       = t.op1;
        id_op2       = f_op2(t.op1);
        id_imm       = f_imm(t.op1);
        id_pc        = t.pc;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_regs(input int idx, input vec_t t);
        chk("valid",     idx, 32'(ex_valid),     32'(t.e_v));
        chk("rs1",       idx, 32'(ex_rs1),       32'(t.e_rs1));
        chk("rs2",       idx, 32'(ex_rs2),       32'(f_rs2(t.e_rs1)));
        chk("need_rs1",  idx, 32'(ex_need_rs1),  32'(t.e_rwe));
        chk("need_rs2",  idx, 32'(ex_need_rs2),  32'(t.e_rwe & ~t.e_rs1[1]));
        chk("rdst",      idx, 32'(ex_rdst),      32'(t.e_rdst));
        chk("r_we",      idx, 32'(ex_r_we),      32'(t.e_rwe));
        chk("read_mem",  idx, 32'(ex_read_mem),  32'(t.e_rwe & t.e_rs1[0]));
        chk("write_mem", idx, 32'(ex_write_mem), 32'(t.e_rwe & t.e_rdst[0]));
        chk("rdst_s",    idx, 32'(ex_rdst_s),    32'(t.e_rdst[1:0]));
        chk("alu_op",    idx, 32'(ex_alu_op),    32'(t.e_rdst[3:0]));
        chk("op1",       idx, ex_op1,            t.e_op1);
        chk("op2",       idx, ex_op2,            f_op2(t.e_op1));
        chk("imm",       idx, ex_imm,            f_imm(t.e_op1));
        chk("pc",        idx, ex_pc,             t.e_pc);
        chk("stall_cnt", idx, 32'(stall_cnt),    32'(t.e_cnt));
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        drive(t);
        #1;
        n_vec++;
        chk("ifid_hold",    idx, 32'(ifid_hold),    32'(t.e_hold));
        chk("exmem_bubble", idx, 32'(exmem_bubble), 32'(t.e_bub));
        @(posedge clk);
        #1;
        chk_regs(idx, t);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t t;
        //          rst ns fl ex clr  v  rs1 rdst rwe op1         pc         hold bub  ev ers1 erdst erwe eop1        epc        ecnt
        vec[0]  = '{0, 0, 0, 0, 0,   0, 0,  0,  0, 32'h0,      32'h0,     0, 0,   0, 0,  0,  0, 32'h0,      32'h0,     16'd0};
        vec[1]  = '{1, 0, 0, 0, 0,   1, 3,  7,  1, 32'h1234,   32'h100,   0, 0,   1, 3,  7,  1, 32'h1234,   32'h100,   16'd0};
        vec[2]  = '{1, 1, 0, 0, 0,   1, 9,  2,  0, 32'h5555,   32'h104,   1, 1,   1, 3,  7,  1, 32'h1234,   32'h100,   16'd1};
        vec[3]  = '{1, 0, 0, 0, 0,   1, 9,  2,  0, 32'h5555,   32'h104,   0, 0,   1, 9,  2,  0, 32'h5555,   32'h104,   16'd1};
        vec[4]  = '{1, 1, 1, 0, 0,   1, 4,  5,  1, 32'hAAAA,   32'h108,   0, 0,   0, 0,  0,  0, 32'h0,      32'h0,     16'd1};
        vec[5]  = '{1, 1, 0, 0, 0,   0, 6,  6,  1, 32'hBBBB,   32'h10C,   0, 0,   0, 6,  6,  0, 32'hBBBB,   32'h10C,   16'd1};
        vec[6]  = '{1, 0, 0, 0, 0,   1, 1,  1,  1, 32'h1,      32'h110,   0, 0,   1, 1,  1,  1, 32'h1,      32'h110,   16'd1};
        vec[7]  = '{1, 0, 0, 1, 0,   1, 2,  2,  1, 32'h2,      32'h114,   1, 0,   1, 1,  1,  1, 32'h1,      32'h110,   16'd2};
        vec[8]  = '{1, 0, 1, 1, 0,   1, 2,  2,  1, 32'h2,      32'h114,   1, 0,   1, 1,  1,  1, 32'h1,      32'h110,   16'd3};
        vec[9]  = '{1, 0, 0, 1, 0,   1, 2,  2,  1, 32'h2,      32'h114,   1, 0,   1, 1,  1,  1, 32'h1,      32'h110,   16'd4};
        vec[10] = '{1, 1, 0, 0, 0,   1, 2,  2,  1, 32'h2,      32'h114,   0, 0,   0, 0,  0,  0, 32'h0,      32'h0,     16'd4};
        vec[11] = '{1, 0, 0, 0, 0,   1, 8,  8,  1, 32'h8,      32'h118,   0, 0,   1, 8,  8,  1, 32'h8,      32'h118,   16'd4};
        vec[12] = '{1, 1, 0, 0, 1,   1, 9,  9,  1, 32'h9,      32'h11C,   1, 1,   1, 8,  8,  1, 32'h8,      32'h118,   16'd0};
        vec[13] = '{1, 0, 0, 1, 1,   1, 9,  9,  1, 32'h9,      32'h11C,   1, 0,   1, 8,  8,  1, 32'h8,      32'h118,   16'd0};
        vec[14] = '{1, 1, 0, 0, 0,   1, 9,  9,  1, 32'h9,      32'h11C,   1, 1,   1, 8,  8,  1, 32'h8,      32'h118,   16'd1};
        vec[15] = '{1, 0, 1, 1, 0,   1, 9,  9,  1, 32'h9,      32'h11C,   1, 0,   1, 8,  8,  1, 32'h8,      32'h118,   16'd2};
        vec[16] = '{0, 1, 0, 1, 0,   1, 9,  9,  1, 32'h9,      32'h11C,   1, 0,   0, 0,  0,  0, 32'h0,      32'h0,     16'd0};
        vec[17] = '{1, 0, 0, 0, 0,   1, 31, 31, 1, 32'hFFFFFFFF, 32'h120, 0, 0,   1, 31, 31, 1, 32'hFFFFFFFF, 32'h120, 16'd0};

        #1;
        for (int i = 0; i < NV; i++) begin
            run_vec(i, vec[i]);
        end

        // Freeze long enough to bring the counter to FFFE, then cross saturation
        t = vec[17];
        t.ex = 1'b1;
        t.v = 1'b0; t.rs1 = 5'd2; t.rdst = 5'd4; t.op1 = 32'h77; t.pc = 32'h200;
        drive(t);
        repeat (65534) @(posedge clk);
        #1;
        n_vec++;
        chk("cnt_fffe", 100, 32'(stall_cnt), 32'h0000FFFE);
        chk("held_op1", 100, ex_op1, 32'hFFFFFFFF);
        t.e_hold = 1'b1;
        t.e_cnt  = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            run_vec(101 + k, t);
        end
        t.clr   = 1'b1;
        t.e_cnt = 16'h0;
        run_vec(104, t);

        // Load-use stall with clear on the same edge
        t.ex    = 1'b0;
        t.ns    = 1'b1;
        t.e_bub = 1'b1;
        run_vec(105, t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
